cpu_control_unit: RTL and testbench

- Hardwired sequencer for the 8-bit datapath: general register file (R1–R4), address register file (PC, AR, SP), 16-bit IR, ALU and byte memory.
- Fetches each 16-bit instruction as two byte reads, decodes it and executes it in 1–2 cycles.
- Drives every select, function and enable line of the datapath.
- Sits above the datapath top level; the only datapath values it reads are IR contents and ALU flags.

---
 rtl/cpu_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// ---------------------------------------------------------------------------
// cpu_control_unit
//
// Hardwired sequencer for the 8-bit datapath (RF R1-R4, ARF PC/AR/SP,
// 16-bit IR, ALU, byte memory). Each 16-bit instruction is fetched as two
// byte reads (T0 high byte, T1 low byte), decoded in DEC and executed in one
// or two cycles (EX1/EX2). All datapath controls are Moore decodes of the
// registered state plus the IR contents and the latched Z flag.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ir[15:0]          IR contents (opcode, DST, S1, S2, IMM fields)
//   alu_flags[3:0]    {O,N,C,Z}; only Z is used (latched by ALU ops)
//   rf_*              register file selects, function, active-low enables
//   arf_*             address register file selects, function, enables
//   ir_en/ir_lh/ir_funsel  IR load enable, half select, function
//   alu_funsel        ALU operation
//   mux_a/b/c_sel     RF input, ARF input and ALU A-input multiplexers
//   mem_cs/mem_wr     memory chip select (active-low) and write strobe
//   halted            high while in HALT
//   state[2:0]        current sequencer state (debug)
//
// Optional build macro: CTRL_SINGLE_STEP_EN
//   Adds step_en/step inputs. With step_en=1 every entry to T0 passes
//   through a WAIT state that holds idle controls until step=1.
// ---------------------------------------------------------------------------
module cpu_control_unit #(
  parameter int OPW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  alu_flags,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step_en,
  input  logic        step,
`endif
  output logic [1:0]  rf_outa_sel,
  output logic [1:0]  rf_outb_sel,
  output logic [1:0]  rf_funsel,
  output logic [3:0]  rf_regsel,
  output logic [1:0]  arf_outc_sel,
  output logic [1:0]  arf_outd_sel,
  output logic [1:0]  arf_funsel,
  output logic [2:0]  arf_regsel,
  output logic        ir_en,
  output logic        ir_lh,
  output logic [1:0]  ir_funsel,
  output logic [3:0]  alu_funsel,
  output logic [1:0]  mux_a_sel,
  output logic [1:0]  mux_b_sel,
  output logic        mux_c_sel,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_DEC  = 3'd3,
    S_EX1  = 3'd4,
    S_EX2  = 3'd5,
    S_HALT = 3'd6,
    S_WAIT = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_AND = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_NOT = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_LSL = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_LSR = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_INC = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_DEC = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_LDI = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_LD  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_ST  = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_BRA = OPW'(4'hC);
  localparam logic [OPW-1:0] OP_BNE = OPW'(4'hD);
  localparam logic [OPW-1:0] OP_NOP = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  state_t         r_state;
  state_t         w_nextState;
  state_t         w_afterInstr;
  logic           r_zFlag;

  logic [OPW-1:0] w_opcode;
  logic [1:0]     w_dst;
  logic [1:0]     w_s1;
  logic [1:0]     w_s2;
  logic [3:0]     w_dstEnN;
  logic           w_isAluOp;
  logic           w_isTwoCycle;
  logic [3:0]     w_aluOp;
  logic           w_unused;

  assign w_opcode = ir[15 -: OPW];
  assign w_dst    = ir[11:10];
  assign w_s1     = ir[9:8];
  assign w_s2     = ir[7:6];

  // Active-low one-hot enable for the destination register (bit0 = R1).
  assign w_dstEnN = ~(4'b0001 << w_dst);

  assign w_isAluOp    = (w_opcode <= OP_LSR);
  assign w_isTwoCycle = (w_opcode == OP_INC) || (w_opcode == OP_DEC) ||
                        (w_opcode == OP_LD)  || (w_opcode == OP_ST);

  // The immediate byte reaches the datapath through the IR mux, and only
  // the Z flag is consumed here.
  assign w_unused = ^{alu_flags[3:1], ir[5:0]};

  // Where the sequencer goes once an instruction is finished.
`ifdef CTRL_SINGLE_STEP_EN
  assign w_afterInstr = step_en ? S_WAIT : S_T0;
`else
  assign w_afterInstr = S_T0;
`endif

  // Opcode to ALU function code for the two-operand/one-operand ALU group.
  always_comb begin
    w_aluOp = 4'h0;
    case (w_opcode)
      OP_AND:  w_aluOp = 4'h7;
      OP_OR:   w_aluOp = 4'h8;
      OP_NOT:  w_aluOp = 4'h2;
      OP_ADD:  w_aluOp = 4'h4;
      OP_SUB:  w_aluOp = 4'h6;
      OP_LSL:  w_aluOp = 4'hA;
      OP_LSR:  w_aluOp = 4'hB;
      default: w_aluOp = 4'h0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Z latch: cleared with the registers, refreshed only by ALU-group ops so
  // INC/DEC and the memory ops leave the branch condition untouched.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_INIT)) begin
      r_zFlag <= 1'b0;
    end else if ((r_state == S_EX1) && w_isAluOp) begin
      r_zFlag <= alu_flags[0];
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_INIT: w_nextState = w_afterInstr;
      S_T0:   w_nextState = S_T1;
      S_T1:   w_nextState = S_DEC;
      S_DEC: begin
        if (w_opcode == OP_HLT) begin
          w_nextState = S_HALT;
        end else if (w_opcode == OP_NOP) begin
          w_nextState = w_afterInstr;
        end else begin
          w_nextState = S_EX1;
        end
      end
      S_EX1:  w_nextState = w_isTwoCycle ? S_EX2 : w_afterInstr;
      S_EX2:  w_nextState = w_afterInstr;
      S_HALT: w_nextState = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      S_WAIT: w_nextState = step ? S_T0 : S_WAIT;
`endif
      default: w_nextState = S_INIT;
    endcase
  end

  // Output decode. While rst is high every enable is held idle so that the
  // write strobe of an interrupted instruction (e.g. ST in EX2) never lands
  // on the reset edge.
  always_comb begin
    rf_outa_sel  = 2'd0;
    rf_outb_sel  = 2'd0;
    rf_funsel    = 2'd0;
    rf_regsel    = 4'b1111;
    arf_outc_sel = 2'd0;
    arf_outd_sel = 2'd0;
    arf_funsel   = 2'd0;
    arf_regsel   = 3'b111;
    ir_en        = 1'b0;
    ir_lh        = 1'b0;
    ir_funsel    = 2'd0;
    alu_funsel   = 4'h0;
    mux_a_sel    = 2'd0;
    mux_b_sel    = 2'd0;
    mux_c_sel    = 1'b0;
    mem_cs       = 1'b1;
    mem_wr       = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_INIT: begin
          rf_funsel  = 2'd3;
          rf_regsel  = 4'b0000;
          arf_funsel = 2'd3;
          arf_regsel = 3'b000;
        end
        S_T0, S_T1: begin
          arf_outd_sel = 2'd0;
          mem_cs       = 1'b0;
          ir_en        = 1'b1;
          ir_lh        = (r_state == S_T1);
          ir_funsel    = 2'd2;
          arf_funsel   = 2'd1;
          arf_regsel   = 3'b110;
        end
        S_EX1: begin
          case (w_opcode)
            OP_AND, OP_OR, OP_NOT, OP_ADD, OP_SUB, OP_LSL, OP_LSR: begin
              rf_outa_sel = w_s1;
              rf_outb_sel = w_s2;
              alu_funsel  = w_aluOp;
              mux_c_sel   = 1'b0;
              mux_a_sel   = 2'd0;
              rf_funsel   = 2'd2;
              rf_regsel   = w_dstEnN;
            end
            OP_INC, OP_DEC: begin
              rf_outa_sel = w_s1;
              alu_funsel  = 4'h0;
              mux_a_sel   = 2'd0;
              rf_funsel   = 2'd2;
              rf_regsel   = w_dstEnN;
            end
            OP_LDI: begin
              mux_a_sel = 2'd2;
              rf_funsel = 2'd2;
              rf_regsel = w_dstEnN;
            end
            OP_LD, OP_ST: begin
              mux_b_sel  = 2'd2;
              arf_funsel = 2'd2;
              arf_regsel = 3'b101;
            end
            OP_BRA: begin
              mux_b_sel  = 2'd2;
              arf_funsel = 2'd2;
              arf_regsel = 3'b110;
            end
            OP_BNE: begin
              if (!r_zFlag) begin
                mux_b_sel  = 2'd2;
                arf_funsel = 2'd2;
                arf_regsel = 3'b110;
              end
            end
            default: ;
          endcase
        end
        S_EX2: begin
          case (w_opcode)
            OP_INC: begin
              rf_funsel = 2'd1;
              rf_regsel = w_dstEnN;
            end
            OP_DEC: begin
              rf_funsel = 2'd0;
              rf_regsel = w_dstEnN;
            end
            OP_LD: begin
              arf_outd_sel = 2'd2;
              mem_cs       = 1'b0;
              mux_a_sel    = 2'd1;
              rf_funsel    = 2'd2;
              rf_regsel    = w_dstEnN;
            end
            OP_ST: begin
              arf_outd_sel = 2'd2;
              rf_outa_sel  = w_dst;
              alu_funsel   = 4'h0;
              mem_cs       = 1'b0;
              mem_wr       = 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_unit
//
// Drives cpu_control_unit against a small behavioural model of the 8-bit
// datapath (RF, ARF, IR, ALU, 256-byte memory). The program lives in the
// model memory; expected control values and datapath results are pushed to a
// scoreboard keyed by cycle number and compared one cycle at a time.
// ---------------------------------------------------------------------------
module tb_cpu_control_unit;

  localparam int F_STATE  = 0;
  localparam int F_RFA    = 1;
  localparam int F_RFB    = 2;
  localparam int F_RFFUN  = 3;
  localparam int F_RFREG  = 4;
  localparam int F_ARFD   = 5;
  localparam int F_ARFFUN = 6;
  localparam int F_ARFREG = 7;
  localparam int F_IREN   = 8;
  localparam int F_IRLH   = 9;
  localparam int F_ALU    = 10;
  localparam int F_MUXA   = 11;
  localparam int F_MUXB   = 12;
  localparam int F_CS     = 13;
  localparam int F_WR     = 14;
  localparam int F_HALT   = 15;
  localparam int F_PC     = 16;
  localparam int F_MEM40  = 17;
  localparam int F_R1     = 18;
  localparam int F_R2     = 19;
  localparam int F_R3     = 20;
  localparam int F_R4     = 21;
  localparam int F_IRFUN  = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic [3:0]  aluFlags;
  logic [1:0]  rfOutaSel, rfOutbSel, rfFunsel;
  logic [3:0]  rfRegsel;
  logic [1:0]  arfOutcSel, arfOutdSel, arfFunsel;
  logic [2:0]  arfRegsel;
  logic        irEn, irLh;
  logic [1:0]  irFunsel;
  logic [3:0]  aluFunsel;
  logic [1:0]  muxASel, muxBSel;
  logic        muxCSel, memCs, memWr, halted;
  logic [2:0]  dutState;
`ifdef CTRL_SINGLE_STEP_EN
  logic        stepEn;
  logic        stepIn;
`endif

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ir           (ir),
    .alu_flags    (aluFlags),
`ifdef CTRL_SINGLE_STEP_EN
    .step_en      (stepEn),
    .step         (stepIn),
`endif
    .rf_outa_sel  (rfOutaSel),
    .rf_outb_sel  (rfOutbSel),
    .rf_funsel    (rfFunsel),
    .rf_regsel    (rfRegsel),
    .arf_outc_sel (arfOutcSel),
    .arf_outd_sel (arfOutdSel),
    .arf_funsel   (arfFunsel),
    .arf_regsel   (arfRegsel),
    .ir_en        (irEn),
    .ir_lh        (irLh),
    .ir_funsel    (irFunsel),
    .alu_funsel   (aluFunsel),
    .mux_a_sel    (muxASel),
    .mux_b_sel    (muxBSel),
    .mux_c_sel    (muxCSel),
    .mem_cs       (memCs),
    .mem_wr       (memWr),
    .halted       (halted),
    .state        (dutState)
  );

  // Behavioural datapath model driven by the controller outputs.
  logic [7:0]  rfReg [4];
  logic [7:0]  pcReg, arReg, spReg;
  logic [7:0]  memArr [256];
  logic [15:0] irReg;
  logic        loadProg, pokeEn;
  logic [7:0]  pokeAddr, pokeData;
  logic [7:0]  rfA, rfB, arfC, arfD, aluA, aluOut, memOut, muxAOut, muxBOut;

  assign ir = irReg;

  // Program: 00 LDI R2,5 / ADD R3,R2,R2 / SUB R4,R2,R2 / BNE 20 / BRA 20
  //          20 ST R3,40 / LD R1,40 / INC R1 / HLT
  function automatic logic [7:0] progByte(input int a);
    case (a)
      0: return 8'h94;   1: return 8'h05;
      2: return 8'h39;   3: return 8'h40;
      4: return 8'h4D;   5: return 8'h40;
      6: return 8'hD0;   7: return 8'h20;
      8: return 8'hC0;   9: return 8'h20;
      32: return 8'hB8;  33: return 8'h40;
      34: return 8'hA0;  35: return 8'h40;
      36: return 8'h70;  37: return 8'h00;
      38: return 8'hF0;  39: return 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] arfPick(input logic [1:0] sel, input logic [7:0] pc,
                                         input logic [7:0] ar, input logic [7:0] sp);
    if (sel == 2'd2) return ar;
    if (sel == 2'd3) return sp;
    return pc;
  endfunction

  function automatic logic [7:0] regUpdate(input logic [1:0] fun, input logic [7:0] cur,
                                           input logic [7:0] din);
    case (fun)
      2'd0:    return cur - 8'd1;
      2'd1:    return cur + 8'd1;
      2'd2:    return din;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    rfA    = rfReg[rfOutaSel];
    rfB    = rfReg[rfOutbSel];
    arfC   = arfPick(arfOutcSel, pcReg, arReg, spReg);
    arfD   = arfPick(arfOutdSel, pcReg, arReg, spReg);
    memOut = memArr[arfD];
    aluA   = muxCSel ? arfC : rfA;
    case (aluFunsel)
      4'h4:    aluOut = aluA + rfB;
      4'h6:    aluOut = aluA - rfB;
      4'h7:    aluOut = aluA & rfB;
      4'h8:    aluOut = aluA | rfB;
      4'h2:    aluOut = ~aluA;
      4'hA:    aluOut = aluA << 1;
      4'hB:    aluOut = aluA >> 1;
      default: aluOut = aluA;
    endcase
    aluFlags = {1'b0, aluOut[7], 1'b0, (aluOut == 8'h00)};
    case (muxASel)
      2'd0:    muxAOut = aluOut;
      2'd1:    muxAOut = memOut;
      2'd2:    muxAOut = irReg[7:0];
      default: muxAOut = arfC;
    endcase
    case (muxBSel)
      2'd0:    muxBOut = aluOut;
      2'd1:    muxBOut = memOut;
      2'd2:    muxBOut = irReg[7:0];
      default: muxBOut = arfC;
    endcase
  end

  always @(posedge clk) begin
    if (loadProg) begin
      for (int i = 0; i < 256; i++) memArr[i] <= progByte(i);
    end else if (pokeEn) begin
      memArr[pokeAddr] <= pokeData;
    end else if (!memCs && memWr) begin
      memArr[arfD] <= aluOut;
    end
    for (int i = 0; i < 4; i++) begin
      if (!rfRegsel[i]) rfReg[i] <= regUpdate(rfFunsel, rfReg[i], muxAOut);
    end
    if (!arfRegsel[0]) pcReg <= regUpdate(arfFunsel, pcReg, muxBOut);
    if (!arfRegsel[1]) arReg <= regUpdate(arfFunsel, arReg, muxBOut);
    if (!arfRegsel[2]) spReg <= regUpdate(arfFunsel, spReg, muxBOut);
    if (irEn) begin
      if (irLh) irReg[7:0] <= memOut;
      else      irReg[15:8] <= memOut;
    end
  end

  // Scoreboard of expected values, each tagged with the cycle it applies to.
  typedef struct {
    int         cyc;
    int         fld;
    logic [7:0] val;
    string      tag;
  } expT;

  expT sbQ[$];
  int  cycleCount = 0;
  int  checkCount = 0;
  int  passCount  = 0;
  int  failCount  = 0;

  function automatic logic [7:0] fieldVal(input int f);
    case (f)
      F_STATE:  return {5'b0, dutState};
      F_RFA:    return {6'b0, rfOutaSel};
      F_RFB:    return {6'b0, rfOutbSel};
      F_RFFUN:  return {6'b0, rfFunsel};
      F_RFREG:  return {4'b0, rfRegsel};
      F_ARFD:   return {6'b0, arfOutdSel};
      F_ARFFUN: return {6'b0, arfFunsel};
      F_ARFREG: return {5'b0, arfRegsel};
      F_IREN:   return {7'b0, irEn};
      F_IRLH:   return {7'b0, irLh};
      F_ALU:    return {4'b0, aluFunsel};
      F_MUXA:   return {6'b0, muxASel};
      F_MUXB:   return {6'b0, muxBSel};
      F_CS:     return {7'b0, memCs};
      F_WR:     return {7'b0, memWr};
      F_HALT:   return {7'b0, halted};
      F_PC:     return pcReg;
      F_MEM40:  return memArr[8'h40];
      F_R1:     return rfReg[0];
      F_R2:     return rfReg[1];
      F_R3:     return rfReg[2];
      F_R4:     return rfReg[3];
      F_IRFUN:  return {6'b0, irFunsel};
      default:  return 8'hxx;
    endcase
  endfunction

  // off = 0 is the next sampled cycle.
  task automatic pushExp(input int off, input int fld, input logic [7:0] val, input string tag);
    sbQ.push_back('{cyc: cycleCount + 1 + off, fld: fld, val: val, tag: tag});
  endtask

  task automatic checkOutput();
    expT        e;
    logic [7:0] obs;
    int         i;
    i = 0;
    while (i < sbQ.size()) begin
      if (sbQ[i].cyc <= cycleCount) begin
        e = sbQ[i];
        sbQ.delete(i);
        obs = fieldVal(e.fld);
        checkCount++;
        assert (obs === e.val) passCount++;
        else begin
          failCount++;
          $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", e.tag, obs, e.val, cycleCount);
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycleCount++;
    checkOutput();
  endtask

  task automatic stepN(input int n);
    repeat (n) stepCycle();
  endtask

  // Fetch expectations common to every instruction starting at the next cycle.
  task automatic applyStimulus(input string name);
    pushExp(0, F_STATE,  3'd1,   {name, "_t0_state"});
    pushExp(0, F_IREN,   1'b1,   {name, "_t0_ir_en"});
    pushExp(0, F_IRLH,   1'b0,   {name, "_t0_ir_lh"});
    pushExp(0, F_IRFUN,  2'd2,   {name, "_t0_ir_funsel"});
    pushExp(0, F_CS,     1'b0,   {name, "_t0_mem_cs"});
    pushExp(0, F_ARFREG, 3'b110, {name, "_t0_arf_regsel"});
    pushExp(0, F_ARFFUN, 2'd1,   {name, "_t0_arf_funsel"});
    pushExp(1, F_STATE,  3'd2,   {name, "_t1_state"});
    pushExp(1, F_IRLH,   1'b1,   {name, "_t1_ir_lh"});
    pushExp(2, F_STATE,  3'd3,   {name, "_dec_state"});
    pushExp(2, F_IREN,   1'b0,   {name, "_dec_ir_en"});
  endtask

  initial begin
    logic found;
    rst      = 1'b1;
    loadProg = 1'b1;
    pokeEn   = 1'b0;
    pokeAddr = 8'h00;
    pokeData = 8'h00;
`ifdef CTRL_SINGLE_STEP_EN
    stepEn   = 1'b0;
    stepIn   = 1'b0;
`endif
    $display("[TB] start");

    // Reset for two cycles, then INIT must clear everything.
    stepCycle();
    loadProg = 1'b0;
    stepCycle();
    rst = 1'b0;
    pushExp(-1, F_STATE,  3'd0,    "init_state");
    pushExp(-1, F_RFREG,  4'b0000, "init_rf_regsel");
    pushExp(-1, F_ARFREG, 3'b000,  "init_arf_regsel");
    pushExp(-1, F_RFFUN,  2'd3,    "init_rf_funsel");
    pushExp(-1, F_ARFFUN, 2'd3,    "init_arf_funsel");
    #1;
    checkOutput();

    // LDI R2,0x05
    applyStimulus("ldi");
    pushExp(3, F_STATE, 3'd4,    "ldi_ex1_state");
    pushExp(3, F_MUXA,  2'd2,    "ldi_ex1_mux_a");
    pushExp(3, F_RFREG, 4'b1101, "ldi_ex1_rf_regsel");
    stepN(4);

    // ADD R3,R2,R2
    applyStimulus("add");
    pushExp(0, F_R2,    8'h05,   "ldi_r2");
    pushExp(3, F_ALU,   4'h4,    "add_ex1_alu");
    pushExp(3, F_RFA,   2'd1,    "add_ex1_outa");
    pushExp(3, F_RFB,   2'd1,    "add_ex1_outb");
    pushExp(3, F_RFREG, 4'b1011, "add_ex1_rf_regsel");
    stepN(4);

    // SUB R4,R2,R2 (result zero sets the Z latch)
    applyStimulus("sub");
    pushExp(0, F_R3,    8'h0A,   "add_r3");
    pushExp(3, F_ALU,   4'h6,    "sub_ex1_alu");
    pushExp(3, F_RFREG, 4'b0111, "sub_ex1_rf_regsel");
    stepN(4);

    // BNE 0x20 is not taken because Z is set
    applyStimulus("bne");
    pushExp(0, F_R4,     8'h00,  "sub_r4");
    pushExp(3, F_STATE,  3'd4,   "bne_ex1_state");
    pushExp(3, F_ARFREG, 3'b111, "bne_ex1_arf_regsel");
    stepN(4);

    // BRA 0x20
    applyStimulus("bra");
    pushExp(0, F_PC,     8'h08,  "bne_pc_not_taken");
    pushExp(3, F_ARFREG, 3'b110, "bra_ex1_arf_regsel");
    pushExp(3, F_MUXB,   2'd2,   "bra_ex1_mux_b");
    pushExp(3, F_ARFFUN, 2'd2,   "bra_ex1_arf_funsel");
    stepN(4);

    // ST R3,0x40 (five cycles)
    applyStimulus("st");
    pushExp(0, F_PC,     8'h20,  "bra_pc");
    pushExp(3, F_STATE,  3'd4,   "st_ex1_state");
    pushExp(3, F_ARFREG, 3'b101, "st_ex1_arf_regsel");
    pushExp(4, F_STATE,  3'd5,   "st_ex2_state");
    pushExp(4, F_ARFD,   2'd2,   "st_ex2_outd");
    pushExp(4, F_WR,     1'b1,   "st_ex2_mem_wr");
    pushExp(4, F_CS,     1'b0,   "st_ex2_mem_cs");
    pushExp(4, F_RFA,    2'd2,   "st_ex2_outa");
    stepN(5);

    // LD R1,0x40
    applyStimulus("ld");
    pushExp(0, F_MEM40,  8'h0A,   "st_mem40");
    pushExp(3, F_ARFREG, 3'b101,  "ld_ex1_arf_regsel");
    pushExp(4, F_STATE,  3'd5,    "ld_ex2_state");
    pushExp(4, F_MUXA,   2'd1,    "ld_ex2_mux_a");
    pushExp(4, F_RFREG,  4'b1110, "ld_ex2_rf_regsel");
    pushExp(4, F_CS,     1'b0,    "ld_ex2_mem_cs");
    stepN(5);

    // INC R1
    applyStimulus("inc");
    pushExp(0, F_R1,    8'h0A,   "ld_r1");
    pushExp(3, F_ALU,   4'h0,    "inc_ex1_alu");
    pushExp(3, F_RFFUN, 2'd2,    "inc_ex1_rf_funsel");
    pushExp(3, F_RFREG, 4'b1110, "inc_ex1_rf_regsel");
    pushExp(4, F_STATE, 3'd5,    "inc_ex2_state");
    pushExp(4, F_RFFUN, 2'd1,    "inc_ex2_rf_funsel");
    pushExp(4, F_RFREG, 4'b1110, "inc_ex2_rf_regsel");
    stepN(5);

    // HLT, then hold for 20 cycles
    applyStimulus("hlt");
    pushExp(0, F_R1, 8'h0B, "inc_r1");
    for (int k = 3; k < 23; k++) begin
      pushExp(k, F_STATE, 3'd6, "halt_state");
      pushExp(k, F_HALT,  1'b1, "halt_flag");
    end
    stepN(23);

    // Reset arriving during the EX2 of a later ST must not write memory.
    pokeEn   = 1'b1;
    pokeAddr = 8'h40;
    pokeData = 8'h55;
    stepCycle();
    pokeEn = 1'b0;
    rst    = 1'b1;
    pushExp(0, F_STATE, 3'd0, "rst_from_halt_state");
    pushExp(0, F_HALT,  1'b0, "rst_from_halt_flag");
    stepCycle();
    rst   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      stepCycle();
      if (dutState == 3'd5 && ir == 16'hB840) found = 1'b1;
    end
    checkCount++;
    assert (found === 1'b1) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL st_ex2_reach: observed timeout after 60 cycles required ST in EX2");
    end
    rst = 1'b1;
    pushExp(0, F_STATE, 3'd0,  "abort_state");
    pushExp(0, F_WR,    1'b0,  "abort_mem_wr");
    pushExp(0, F_HALT,  1'b0,  "abort_halted");
    pushExp(0, F_MEM40, 8'h55, "abort_mem40");
    stepCycle();
    rst = 1'b0;

`ifdef CTRL_SINGLE_STEP_EN
    // Single-step: park in WAIT, then one step pulse runs exactly one LDI.
    stepEn = 1'b1;
    rst    = 1'b1;
    stepCycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) pushExp(k, F_STATE, 3'd7, "wait_hold");
    stepN(10);
    stepIn = 1'b1;
    pushExp(0, F_STATE, 3'd1, "step_t0");
    stepCycle();
    stepIn = 1'b0;
    pushExp(0, F_STATE, 3'd2,  "step_t1");
    pushExp(1, F_STATE, 3'd3,  "step_dec");
    pushExp(2, F_STATE, 3'd4,  "step_ex1");
    pushExp(2, F_MUXA,  2'd2,  "step_ex1_mux_a");
    pushExp(3, F_STATE, 3'd7,  "step_back_wait");
    pushExp(3, F_R2,    8'h05, "step_r2");
    pushExp(4, F_STATE, 3'd7,  "step_wait_again");
    pushExp(4, F_PC,    8'h02, "step_pc");
    stepN(5);
`endif

    // Anything still queued was never reached.
    while (sbQ.size() > 0) begin
      expT e;
      e = sbQ.pop_front();
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s: observed not reached expected 0x%0h", e.tag, e.val);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
